mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit.sv | 128 ++++++++++++
 tb/tb_mult_div_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative 32x32 multiply / divide with architectural HI/LO; one bit per cycle over 32 steps.
// Latency: 34 cycles from start to result; mthi/mtlo land in 1 cycle. Start and mthi/mtlo are ignored while busy.
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic [31:0] opnd;     // multiplicand magnitude for mult, divisor magnitude for div
    logic [31:0] acc_hi;   // product high half / partial remainder
    logic [31:0] acc_lo;   // multiplier bits / quotient bits

    logic        is_signed;
    logic        b_zero;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [32:0] add_sum;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic        div_ge;
    logic [63:0] product;

    always_comb begin
        is_signed = ~op[0];
        b_zero    = (b == 32'd0);
        a_abs     = (is_signed && a[31]) ? (32'd0 - a) : a;
        b_abs     = (is_signed && b[31]) ? (32'd0 - b) : b;

        add_sum = acc_lo[0] ? ({1'b0, acc_hi} + {1'b0, opnd}) : {1'b0, acc_hi};

        // Remainder stays below the divisor, so a 33-bit trial's MSB is its sign.
        rem_sh = {acc_hi, acc_lo[31]};
        trial  = rem_sh - {1'b0, opnd};
        div_ge = ~trial[32];

        product = {acc_hi, acc_lo};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            opnd    <= 32'd0;
            acc_hi  <= 32'd0;
            acc_lo  <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        busy   <= 1'b1;
                        cnt    <= 5'd0;
                        is_div <= op[1];
                        acc_hi <= 32'd0;
                        if (op[1]) begin
                            // Divide by zero keeps the raw dividend so it falls out as HI.
                            opnd    <= b_abs;
                            acc_lo  <= b_zero ? a : a_abs;
                            neg_res <= is_signed & ~b_zero & (a[31] ^ b[31]);
                            neg_rem <= is_signed & ~b_zero & a[31];
                        end else begin
                            opnd    <= a_abs;
                            acc_lo  <= b_abs;
                            neg_res <= is_signed & (a[31] ^ b[31]);
                            neg_rem <= 1'b0;
                        end
                    end else begin
                        if (mthi)
                            hi <= wdata;
                        if (mtlo)
                            lo <= wdata;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        acc_hi <= div_ge ? trial[31:0] : rem_sh[31:0];
                        acc_lo <= {acc_lo[30:0], div_ge};
                    end else begin
                        acc_hi <= add_sum[32:1];
                        acc_lo <= {add_sum[0], acc_lo[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= FIX;
                end
                FIX: begin
                    if (is_div) begin
                        lo <= neg_res ? (32'd0 - acc_lo) : acc_lo;
                        hi <= neg_rem ? (32'd0 - acc_hi) : acc_hi;
                    end else begin
                        {hi, lo} <= neg_res ? (64'd0 - product) : product;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vectors, random ops against an arithmetic model,
// back-to-back issue, mthi/mtlo, ignored inputs and mid-operation reset.
module tb_mult_div_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: returns {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sx, sy, q, r;
        logic [31:0]        qv, rv;
        case (o)
            2'd0: begin
                sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return sp;
            end
            2'd1: begin
                up = {32'd0, x} * {32'd0, y};
                return up;
            end
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                sx = x; sy = y;
                q = sx / sy; r = sx % sy;
                qv = q; rv = r;
                return {rv, qv};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
        endcase
    endfunction

    // b2b: drive start immediately (caller is in a done cycle); chain: skip the post-done check.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit b2b, input bit chain);
        logic [63:0] exp;
        logic [31:0] oh, ol;
        bit          ok;
        exp = model(o, x, y);
        if (!b2b) @(negedge clk);
        oh = hi; ol = lo;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
        ok = 1'b1;
        for (int i = 0; i <= 32; i++) begin
            if (busy !== 1'b1 || done !== 1'b0 || hi !== oh || lo !== ol) ok = 1'b0;
            @(posedge clk); #1;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL run_phase op=%0d a=%h b=%h: busy/done/hi/lo not held during run (required busy=1 done=0 hi=%h lo=%h)",
                     o, x, y, oh, ol);
        end
        total++;
        if ({busy, done} !== 2'b01) begin
            bad++;
            $display("FAIL done_pulse op=%0d a=%h b=%h: got busy=%b done=%b, required busy=0 done=1", o, x, y, busy, done);
        end
        total++;
        if ({hi, lo} !== exp) begin
            bad++;
            $display("FAIL result op=%0d a=%h b=%h: got hi=%h lo=%h, required hi=%h lo=%h",
                     o, x, y, hi, lo, exp[63:32], exp[31:0]);
        end
        if (!chain) begin
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL done_width op=%0d: got done=%b, required 0", o, done);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            bad++;
            $display("FAIL reset: got busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        do_op(2'd0, 32'hFFFF_FFFD, 32'd5,         1'b0, 1'b0);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2,         1'b0, 1'b0);
        do_op(2'd3, 32'd7,         32'd0,         1'b0, 1'b0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd0,         1'b0, 1'b0);
        do_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        do_op(2'd2, 32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y;
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 4))
                0: y = 32'd0;
                1: begin x = $urandom_range(0, 255); y = $urandom_range(1, 15); end
                2: y = {{28{y[31]}}, y[3:0]};
                default: ;
            endcase
            do_op(o, x, y, 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        do_op(2'd1, 32'd1000,       32'd3000,     1'b0, 1'b1);
        do_op(2'd3, 32'd1000,       32'd7,        1'b1, 1'b1);
        do_op(2'd2, 32'hFFFF_FC18,  32'd7,        1'b1, 1'b1);
        do_op(2'd0, $urandom,       $urandom,     1'b1, 1'b0);
    endtask

    task automatic test_mthi_mtlo();
        @(negedge clk);
        mthi = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        mthi = 1'b0;
        total++;
        if (hi !== 32'h1234_5678 || done !== 1'b0) begin
            bad++;
            $display("FAIL mthi: got hi=%h done=%b, required hi=12345678 done=0", hi, done);
        end
        @(negedge clk);
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        total++;
        if (hi !== 32'hCAFE_F00D || lo !== 32'hCAFE_F00D || busy !== 1'b0) begin
            bad++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h busy=%b, required hi=lo=cafef00d busy=0", hi, lo, busy);
        end
    endtask

    task automatic test_ignored_inputs();
        int  dones;
        bit  seen;
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 2'd2; mtlo = 1'b1; mthi = 1'b1; wdata = 32'hDEAD_BEEF; a = 32'd100; b = 32'd9;
        @(posedge clk); #1;
        start = 1'b0; mtlo = 1'b0; mthi = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL ignore_timeout: done never seen, required within 40 cycles");
        end
        total++;
        if (hi !== 32'd0 || lo !== 32'd12) begin
            bad++;
            $display("FAIL ignore_result: got hi=%h lo=%h, required hi=0 lo=c", hi, lo);
        end
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0) begin
            bad++;
            $display("FAIL ignore_no_second_op: got %0d busy/done cycles, required 0", dones);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        @(negedge clk);
        start = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({busy, done, hi, lo} !== 66'd0) begin
            bad++;
            $display("FAIL reset_abort: got busy=%b done=%b hi=%h lo=%h, required all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
        end
        total++;
        if (dones !== 0 || hi !== 32'd0 || lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_abort_quiet: got %0d busy/done cycles hi=%h lo=%h, required 0/0/0", dones, hi, lo);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'd0; a = 32'd0; b = 32'd0;
        mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
        repeat (2) @(posedge clk);
        test_reset();
        test_mthi_mtlo();
        test_vectors();
        test_random();
        test_back_to_back();
        test_ignored_inputs();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
